// File: rtl/beat_sequencer.sv
// beat_sequencer: play/pause/stop/repeat sequencer for the lab08 audio player.
// Drives the music ROM beat index and the note generator silence flag.
//
// Ports:
//   clk        crystal clock
//   rst        asynchronous reset, active-low
//   play       switch, 1 = play / 0 = pause (asynchronous)
//   rpt        switch, repeat enable (asynchronous)
//   music      switch, song select (asynchronous)
//   ibeat      current beat index, 0..len-1
//   now_state  00 STOP, 01 PLAY, 10 PAUSE, 11 DONE
//   beat_tick  1-cycle pulse on each beat advance attempt in PLAY
//   song_done  1-cycle pulse when the last beat completes
//   silent     1 whenever now_state is not PLAY

module beat_sequencer #(
    parameter int TICK_DIV = 4194304,
    parameter int LEN0     = 512,
    parameter int LEN1     = 576,
    parameter int BW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          play,
    input  logic          rpt,
    input  logic          music,
    output logic [BW-1:0] ibeat,
    output logic [1:0]    now_state,
    output logic          beat_tick,
    output logic          song_done,
    output logic          silent
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] LEN0_M1  = BW'(LEN0 - 1);
    localparam logic [BW-1:0] LEN1_M1  = BW'(LEN1 - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [BW-1:0] ibeat_q, ibeat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    // Two-stage synchronizers for the asynchronous switches
    logic          play_m_q, play_s_q;
    logic          rpt_m_q, rpt_s_q;
    logic          music_m_q, music_s_q;
    logic          music_prev_q;

    logic          music_edge;
    logic [BW-1:0] len_m1;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play_m_q     <= 1'b0;
            play_s_q     <= 1'b0;
            rpt_m_q      <= 1'b0;
            rpt_s_q      <= 1'b0;
            music_m_q    <= 1'b0;
            music_s_q    <= 1'b0;
            music_prev_q <= 1'b0;
        end else begin
            play_m_q     <= play;
            play_s_q     <= play_m_q;
            rpt_m_q      <= rpt;
            rpt_s_q      <= rpt_m_q;
            music_m_q    <= music;
            music_s_q    <= music_m_q;
            music_prev_q <= music_s_q;
        end
    end

    // Any change of the synchronized song select restarts the song
    assign music_edge = music_s_q ^ music_prev_q;

    // Index of the last beat of the selected song
    assign len_m1 = music_s_q ? LEN1_M1 : LEN0_M1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
            ibeat_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ibeat_q <= ibeat_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // Priority: music restart > pause/stop request > beat action.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ibeat_d = ibeat_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (music_edge) begin
            ibeat_d = '0;
            cnt_d   = '0;
            state_d = play_s_q ? ST_PLAY : ST_STOP;
        end else begin
            unique case (state_q)
                ST_STOP: begin
                    ibeat_d = '0;
                    cnt_d   = '0;
                    if (play_s_q) begin
                        state_d = ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (!play_s_q) begin
                        // Freeze beat and counter; a coincident tick is dropped
                        state_d = ST_PAUSE;
                    end else begin
                        if (tick_q) begin
                            if (ibeat_q >= len_m1) begin
                                done_d = 1'b1;
                                if (rpt_s_q) begin
                                    ibeat_d = '0;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                ibeat_d = ibeat_q + BW'(1);
                            end
                        end
                        // Registered tick: pulse lands as the counter wraps
                        if (cnt_q == TICK_MAX) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end

                ST_PAUSE: begin
                    // Counter keeps its value so the resumed beat is not stretched
                    if (play_s_q) begin
                        state_d = ST_PLAY;
                    end
                end

                ST_DONE: begin
                    cnt_d = '0;
                    if (!play_s_q) begin
                        state_d = ST_STOP;
                        ibeat_d = '0;
                    end else if (rpt_s_q) begin
                        state_d = ST_PLAY;
                        ibeat_d = '0;
                    end
                end

                default: begin
                    state_d = ST_STOP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ibeat     = ibeat_q;
    assign now_state = state_q;
    assign beat_tick = tick_q;
    assign song_done = done_q;
    assign silent    = (state_q != ST_PLAY);

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed self-checking bench for beat_sequencer
// with a short beat (TICK_DIV=4) and short songs (8 and 12 beats).

module tb_beat_sequencer;

    localparam int TD = 4;
    localparam int L0 = 8;
    localparam int L1 = 12;
    localparam int BW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          play = 1'b0;
    logic          rpt = 1'b0;
    logic          music = 1'b0;
    logic [BW-1:0] ibeat;
    logic [1:0]    now_state;
    logic          beat_tick;
    logic          song_done;
    logic          silent;

    int checks = 0;
    int errors = 0;

    beat_sequencer #(
        .TICK_DIV(TD),
        .LEN0    (L0),
        .LEN1    (L1),
        .BW      (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .rpt      (rpt),
        .music    (music),
        .ibeat    (ibeat),
        .now_state(now_state),
        .beat_tick(beat_tick),
        .song_done(song_done),
        .silent   (silent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until now_state matches or the budget runs out
    task automatic wait_for_state(input logic [1:0] want, input int budget,
                                  output int used);
        used = 0;
        while (now_state !== want && used < budget) begin
            tick();
            used++;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        play  = 1'b0;
        rpt   = 1'b0;
        music = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int nt;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({now_state, ibeat, silent, beat_tick, song_done} !==
            {2'b00, 12'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: st=%b ib=%0d sil=%b bt=%b sd=%b, want st=00 ib=0 sil=1 bt=0 sd=0",
                     now_state, ibeat, silent, beat_tick, song_done);
        end
        repeat (3) tick();
        rst = 1'b1;
        nt = 0;
        repeat (50) begin
            tick();
            if (beat_tick === 1'b1) nt++;
        end
        checks++;
        if (nt !== 0) begin
            errors++;
            $display("FAIL reset_no_tick: %0d beat_ticks, want 0", nt);
        end
        checks++;
        if ({now_state, ibeat, silent} !== {2'b00, 12'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_idle: st=%b ib=%0d sil=%b, want st=00 ib=0 sil=1",
                     now_state, ibeat, silent);
        end
    endtask

    task automatic test_play_once();
        int n;
        logic [BW-1:0] eib;
        logic [1:0] est;
        logic ebt, esd;
        play = 1'b1;
        wait_for_state(2'b01, 3, n);
        checks++;
        if (now_state !== 2'b01 || silent !== 1'b0) begin
            errors++;
            $display("FAIL once_enter_play: st=%b sil=%b after %0d cycles, want st=01 sil=0",
                     now_state, silent, n);
        end
        for (int cyc = 1; cyc <= 36; cyc++) begin
            tick();
            eib = (cyc >= 33) ? BW'(7) : BW'((cyc - 1) / 4);
            est = (cyc >= 33) ? 2'b11 : 2'b01;
            ebt = (cyc % 4 == 0) && (cyc <= 32);
            esd = (cyc == 33);
            checks++;
            if ({ibeat, now_state, beat_tick, song_done} !== {eib, est, ebt, esd}) begin
                errors++;
                $display("FAIL once_cyc%0d: ib=%0d st=%b bt=%b sd=%b, want ib=%0d st=%b bt=%b sd=%b",
                         cyc, ibeat, now_state, beat_tick, song_done, eib, est, ebt, esd);
            end
        end
        play = 1'b0;
        wait_for_state(2'b00, 4, n);
        checks++;
        if ({now_state, ibeat, silent} !== {2'b00, 12'd0, 1'b1}) begin
            errors++;
            $display("FAIL once_done_to_stop: st=%b ib=%0d sil=%b, want st=00 ib=0 sil=1",
                     now_state, ibeat, silent);
        end
    endtask

    task automatic test_repeat();
        int n;
        logic [BW-1:0] eib;
        logic ebt, esd;
        do_reset();
        rpt  = 1'b1;
        play = 1'b1;
        wait_for_state(2'b01, 3, n);
        checks++;
        if (now_state !== 2'b01) begin
            errors++;
            $display("FAIL rpt_enter_play: st=%b, want 01", now_state);
        end
        for (int cyc = 1; cyc <= 68; cyc++) begin
            tick();
            eib = BW'(((cyc - 1) / 4) % 8);
            ebt = (cyc % 4 == 0);
            esd = (cyc == 33) || (cyc == 65);
            checks++;
            if ({ibeat, now_state, beat_tick, song_done} !== {eib, 2'b01, ebt, esd}) begin
                errors++;
                $display("FAIL rpt_cyc%0d: ib=%0d st=%b bt=%b sd=%b, want ib=%0d st=01 bt=%b sd=%b",
                         cyc, ibeat, now_state, beat_tick, song_done, eib, ebt, esd);
            end
        end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        play = 1'b1;
        wait_for_state(2'b01, 3, n);
        checks++;
        if (now_state !== 2'b01) begin
            errors++;
            $display("FAIL pause_enter_play: st=%b, want 01", now_state);
        end
        repeat (12) tick();
        play = 1'b0;
        repeat (2) tick();
        checks++;
        if ({now_state, ibeat} !== {2'b01, 12'd3}) begin
            errors++;
            $display("FAIL pause_before: st=%b ib=%0d, want st=01 ib=3", now_state, ibeat);
        end
        tick();
        checks++;
        if ({now_state, ibeat, silent} !== {2'b10, 12'd3, 1'b1}) begin
            errors++;
            $display("FAIL pause_enter: st=%b ib=%0d sil=%b, want st=10 ib=3 sil=1",
                     now_state, ibeat, silent);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({now_state, ibeat, beat_tick} !== {2'b10, 12'd3, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold%0d: st=%b ib=%0d bt=%b, want st=10 ib=3 bt=0",
                         i, now_state, ibeat, beat_tick);
            end
        end
        play = 1'b1;
        repeat (3) tick();
        checks++;
        if ({now_state, ibeat, beat_tick} !== {2'b01, 12'd3, 1'b0}) begin
            errors++;
            $display("FAIL pause_resume: st=%b ib=%0d bt=%b, want st=01 ib=3 bt=0",
                     now_state, ibeat, beat_tick);
        end
        tick();
        checks++;
        if (beat_tick !== 1'b0) begin
            errors++;
            $display("FAIL pause_resume_p1: bt=%b, want 0", beat_tick);
        end
        tick();
        checks++;
        if ({beat_tick, ibeat} !== {1'b1, 12'd3}) begin
            errors++;
            $display("FAIL pause_resume_tick: bt=%b ib=%0d, want bt=1 ib=3", beat_tick, ibeat);
        end
        tick();
        checks++;
        if ({beat_tick, ibeat} !== {1'b0, 12'd4}) begin
            errors++;
            $display("FAIL pause_resume_adv: bt=%b ib=%0d, want bt=0 ib=4", beat_tick, ibeat);
        end
    endtask

    task automatic test_music_switch();
        int n;
        logic [BW-1:0] eib;
        logic [1:0] est;
        logic ebt, esd;
        do_reset();
        play = 1'b1;
        wait_for_state(2'b01, 3, n);
        checks++;
        if (now_state !== 2'b01) begin
            errors++;
            $display("FAIL music_enter_play: st=%b, want 01", now_state);
        end
        repeat (21) tick();
        music = 1'b1;
        for (int cyc = 22; cyc <= 23; cyc++) begin
            tick();
            checks++;
            if ({ibeat, now_state, beat_tick, song_done} !== {12'd5, 2'b01, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL music_pre%0d: ib=%0d st=%b bt=%b sd=%b, want ib=5 st=01 bt=0 sd=0",
                         cyc, ibeat, now_state, beat_tick, song_done);
            end
        end
        tick();
        checks++;
        if ({ibeat, now_state, beat_tick, song_done} !== {12'd0, 2'b01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL music_restart: ib=%0d st=%b bt=%b sd=%b, want ib=0 st=01 bt=0 sd=0",
                     ibeat, now_state, beat_tick, song_done);
        end
        for (int rel = 1; rel <= 49; rel++) begin
            tick();
            eib = (rel == 49) ? BW'(11) : BW'((rel - 1) / 4);
            est = (rel == 49) ? 2'b11 : 2'b01;
            ebt = (rel % 4 == 0) && (rel <= 48);
            esd = (rel == 49);
            checks++;
            if ({ibeat, now_state, beat_tick, song_done} !== {eib, est, ebt, esd}) begin
                errors++;
                $display("FAIL music_rel%0d: ib=%0d st=%b bt=%b sd=%b, want ib=%0d st=%b bt=%b sd=%b",
                         rel, ibeat, now_state, beat_tick, song_done, eib, est, ebt, esd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        play = 1'b1;
        wait_for_state(2'b01, 3, n);
        repeat (6) tick();
        checks++;
        if ({now_state, ibeat} !== {2'b01, 12'd1}) begin
            errors++;
            $display("FAIL midrst_pre: st=%b ib=%0d, want st=01 ib=1", now_state, ibeat);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({now_state, ibeat, silent, beat_tick, song_done} !==
            {2'b00, 12'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_async: st=%b ib=%0d sil=%b bt=%b sd=%b, want st=00 ib=0 sil=1 bt=0 sd=0",
                     now_state, ibeat, silent, beat_tick, song_done);
        end
        repeat (2) tick();
        checks++;
        if ({now_state, song_done} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL midrst_hold: st=%b sd=%b, want st=00 sd=0", now_state, song_done);
        end
        rst = 1'b1;
        wait_for_state(2'b01, 3, n);
        checks++;
        if ({now_state, ibeat} !== {2'b01, 12'd0}) begin
            errors++;
            $display("FAIL midrst_replay: st=%b ib=%0d after %0d cycles, want st=01 ib=0",
                     now_state, ibeat, n);
        end
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_repeat();
        test_pause();
        test_music_switch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Upstream stage of the music ROM and the note generator in the lab08 audio player.
- Owns play/pause/stop/repeat sequencing and music-select restart.
- Produces the beat index that addresses the music ROM, plus a silence flag for the frequency mux.
- Runs on the crystal clock with an internal beat-rate divider, so no derived clock is needed.

Parameters:
TICK_DIV, 4194304, crystal cycles per beat (2^22, the same rate as the 22-bit divided clock)
LEN0, 512, beat count of music 0 (music=0)
LEN1, 576, beat count of music 1 (music=1)
BW, 12, beat index width; LEN0 and LEN1 must each be at most 2^BW

Ports:
clk  in  1  crystal clock
rst  in  1  asynchronous reset, active-low (0 = reset)
play  in  1  switch: 1 = play, 0 = pause; asynchronous
rpt  in  1  switch: repeat enable; asynchronous
music  in  1  switch: song select; asynchronous
ibeat  out  BW  current beat index, 0..len-1
now_state  out  2  00 STOP, 01 PLAY, 10 PAUSE, 11 DONE
beat_tick  out  1  1-cycle pulse on each beat advance attempt in PLAY
song_done  out  1  1-cycle pulse when the last beat completes
silent  out  1  1 whenever now_state != PLAY

Behaviour:
- Reset (rst=0, asynchronous): ibeat=0, now_state=STOP, beat_tick=0, song_done=0, silent=1, tick counter=0, synchronizers=0.
- Input synchronization:
  - play, rpt and music each pass through a 2-FF synchronizer, giving play_s, rpt_s and music_s.
  - All decisions use the synchronized versions, so an input change takes effect 2-3 cycles later.
  - music_edge = music_s differs from its own registered copy.
- len = music_s ? LEN1 : LEN0. Comparisons are unsigned and BW bits wide.
- Tick counter:
  - Counts 0..TICK_DIV-1, advancing only in PLAY.
  - Held in PAUSE.
  - Cleared in STOP and DONE, and on music_edge.
  - beat_tick is registered: it is 1 on the cycle after the counter reaches TICK_DIV-1 while in PLAY, and the counter wraps to 0 at the same time.
- Priority, evaluated every cycle: reset > music_edge > pause/stop request > beat_tick action.
- music_edge, any state: ibeat=0, tick counter=0, now_state = play_s ? PLAY : STOP. No song_done pulse.
- STOP: ibeat=0. If play_s=1, go to PLAY next cycle; the first beat_tick follows TICK_DIV cycles later.
- PLAY:
  - play_s=0: go to PAUSE. ibeat and tick counter are held, and a coincident beat_tick does not advance ibeat.
  - beat_tick with ibeat < len-1: ibeat+1.
  - beat_tick with ibeat = len-1 and rpt_s=1: ibeat=0, stay in PLAY, song_done=1 for one cycle.
  - beat_tick with ibeat = len-1 and rpt_s=0: go to DONE, ibeat holds len-1, song_done=1 for one cycle.
- PAUSE: play_s=1 returns to PLAY. The tick counter resumes from its held value, so the beat is not lengthened.
- DONE:
  - play_s=0: go to STOP, ibeat=0.
  - play_s=1 and rpt_s=1: go to PLAY with ibeat=0.
  - Otherwise hold.
- silent is derived combinationally from the state register: silent = (now_state != PLAY).
- ibeat never exceeds len-1; no overflow or wrap beyond the 0 reset.
- rst asserted mid-song forces the reset values immediately, with no pulse emitted. After release, the block starts in STOP and moves to PLAY only when play_s=1.

Test Plan (TICK_DIV=4, LEN0=8, LEN1=12):
1. rst=0 then released, all switches 0 -> now_state=00, ibeat=0, silent=1, no beat_tick for 50 cycles.
2. play=1, rpt=0, music=0 -> PLAY within 3 cycles; ibeat steps 0..7 at one step per 4 cycles; song_done pulses once at the final tick; now_state=11 with ibeat=7 held; then play=0 -> STOP with ibeat=0.
3. play=1, rpt=1, music=0 -> ibeat wraps 7->0 with a song_done pulse each pass; now_state stays 01.
4. Pause at ibeat=3 when the tick counter is at 2 -> now_state=10, ibeat=3 frozen for 20 cycles; play=1 -> the next beat_tick arrives 2 cycles after PLAY re-entry and ibeat=4.
5. music toggled 0->1 at ibeat=5 while playing -> ibeat=0 and state PLAY; the song now runs to ibeat=11; song_done is not pulsed at the toggle.
6. rst=0 asserted mid-beat while play=1 -> outputs reach reset values in the same cycle with no song_done pulse; after release -> PLAY within 3 cycles and ibeat starts at 0.
